// File: rtl/risc_v_mmio_resp_if.sv
// MMIO request/response bus between the memory controller (master) and the
// MMIO responder (slave). Offsets are relative to the MMIO base.
interface risc_v_mmio_resp_if;
  localparam int ADDRESS_32_W = 32;
  localparam int DATA_32_W    = 32;

  logic                    mmio_wr_val;
  logic [ADDRESS_32_W-1:0] mmio_wr_addr;
  logic [DATA_32_W-1:0]    mmio_wr_data;
  logic                    mmio_rd_val;
  logic [ADDRESS_32_W-1:0] mmio_rd_addr;
  logic [DATA_32_W-1:0]    mmio_rd_data;
  logic                    mmio_rd_data_val;
  logic                    mmio_addr_error;

  modport master (
    output mmio_wr_val, mmio_wr_addr, mmio_wr_data, mmio_rd_val, mmio_rd_addr,
    input  mmio_rd_data, mmio_rd_data_val, mmio_addr_error
  );

  modport slave (
    input  mmio_wr_val, mmio_wr_addr, mmio_wr_data, mmio_rd_val, mmio_rd_addr,
    output mmio_rd_data, mmio_rd_data_val, mmio_addr_error
  );
endinterface

// File: rtl/risc_v_mmio_resp.sv
// MMIO responder: GPIO port, compare timer with interrupt, and a byte TX FIFO
// drained by a ready/valid console sink. Reads return registered data 1 cycle later.
module risc_v_mmio_resp #(
  parameter int GPIO_W        = 8,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  risc_v_mmio_resp_if.slave bus,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);
  localparam int PW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    REG_GPIO_OUT   = 3'd0,
    REG_GPIO_IN    = 3'd1,
    REG_TIMER_CNT  = 3'd2,
    REG_TIMER_CMP  = 3'd3,
    REG_TIMER_CTRL = 3'd4,
    REG_TX_DATA    = 3'd5,
    REG_TX_STATUS  = 3'd6,
    REG_UNMAPPED   = 3'd7
  } reg_e;

  reg_e wr_sel, rd_sel;
  logic wr_map, rd_map;

  assign wr_sel = reg_e'(bus.mmio_wr_addr[4:2]);
  assign rd_sel = reg_e'(bus.mmio_rd_addr[4:2]);
  assign wr_map = (bus.mmio_wr_addr[31:5] == '0) && (wr_sel != REG_UNMAPPED);
  assign rd_map = (bus.mmio_rd_addr[31:5] == '0) && (rd_sel != REG_UNMAPPED);

  logic we_gpio, we_cnt, we_cmp, we_ctrl, we_tx, we_status;
  assign we_gpio   = bus.mmio_wr_val && wr_map && (wr_sel == REG_GPIO_OUT);
  assign we_cnt    = bus.mmio_wr_val && wr_map && (wr_sel == REG_TIMER_CNT);
  assign we_cmp    = bus.mmio_wr_val && wr_map && (wr_sel == REG_TIMER_CMP);
  assign we_ctrl   = bus.mmio_wr_val && wr_map && (wr_sel == REG_TIMER_CTRL);
  assign we_tx     = bus.mmio_wr_val && wr_map && (wr_sel == REG_TX_DATA);
  assign we_status = bus.mmio_wr_val && wr_map && (wr_sel == REG_TX_STATUS);

  // GPIO: output register and 2-flop input synchronizer
  logic [GPIO_W-1:0] gpio_sync1, gpio_sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out   <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
    end else begin
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
      if (we_gpio) gpio_out <= bus.mmio_wr_data[GPIO_W-1:0];
    end
  end

  logic [31:0] tmr_cnt, tmr_cmp;
  logic        tmr_en, tmr_irq_en, tmr_pending, tmr_hit;

  assign tmr_hit   = tmr_en && (tmr_cnt == tmr_cmp);
  assign timer_irq = tmr_pending && tmr_irq_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_cnt     <= '0;
      tmr_cmp     <= '0;
      tmr_en      <= 1'b0;
      tmr_irq_en  <= 1'b0;
      tmr_pending <= 1'b0;
    end else begin
      // A CPU write to CNT takes priority over the wrap and the increment.
      if (we_cnt)       tmr_cnt <= bus.mmio_wr_data;
      else if (tmr_hit) tmr_cnt <= '0;
      else if (tmr_en)  tmr_cnt <= tmr_cnt + 32'd1;
      if (we_cmp) tmr_cmp <= bus.mmio_wr_data;
      if (we_ctrl) begin
        tmr_en     <= bus.mmio_wr_data[0];
        tmr_irq_en <= bus.mmio_wr_data[1];
      end
      tmr_pending <= tmr_hit || (tmr_pending && !(we_ctrl && bus.mmio_wr_data[2]));
    end
  end

  logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, overflow, pop, accept;

  assign fifo_full  = (fifo_count == CW'(TX_FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign tx_valid   = !fifo_empty;
  assign tx_data    = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign pop        = tx_valid && tx_ready;
  // A push into a full FIFO is still accepted when the head leaves the same cycle.
  assign accept     = we_tx && (!fifo_full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      overflow <= (we_tx && !accept) || (overflow && !(we_status && bus.mmio_wr_data[2]));
    end
  end

  // NOTE: storage array has no reset; emptiness is carried by the reset pointers/count.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= bus.mmio_wr_data[7:0];
  end

  logic [31:0] rd_mux;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      REG_GPIO_OUT:   rd_mux = 32'(gpio_out);
      REG_GPIO_IN:    rd_mux = 32'(gpio_sync2);
      REG_TIMER_CNT:  rd_mux = tmr_cnt;
      REG_TIMER_CMP:  rd_mux = tmr_cmp;
      REG_TIMER_CTRL: rd_mux = {29'd0, tmr_pending, tmr_irq_en, tmr_en};
      REG_TX_STATUS: begin
        rd_mux[8:4] = 5'(fifo_count);
        rd_mux[2:0] = {overflow, fifo_empty, fifo_full};
      end
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mmio_rd_data     <= '0;
      bus.mmio_rd_data_val <= 1'b0;
      bus.mmio_addr_error  <= 1'b0;
    end else begin
      bus.mmio_rd_data     <= (bus.mmio_rd_val && rd_map) ? rd_mux : '0;
      bus.mmio_rd_data_val <= bus.mmio_rd_val;
      bus.mmio_addr_error  <= (bus.mmio_wr_val && !wr_map) || (bus.mmio_rd_val && !rd_map);
    end
  end
endmodule

// File: doc/risc_v_mmio_resp.md
# risc_v_mmio_resp

Memory-mapped I/O responder that serves the MMIO region of the data bus. It receives already-decoded, offset-relative MMIO read/write requests from the memory controller and returns registered read data one cycle later. It implements a GPIO port, a compare timer with interrupt, and a byte TX FIFO drained by a ready/valid console sink.

## Interface
- GPIO_W, 8, width of GPIO in/out ports (1..32)
- TX_FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous assert, active-low
- mmio_wr_val  in  1  write request this cycle
- mmio_wr_addr  in  ADDRESS_32_W  byte offset from MMIO base
- mmio_wr_data  in  DATA_32_W  write data
- mmio_rd_val  in  1  read request this cycle
- mmio_rd_addr  in  ADDRESS_32_W  byte offset from MMIO base
- mmio_rd_data  out  DATA_32_W  read data, valid with mmio_rd_data_val
- mmio_rd_data_val  out  1  one-cycle pulse, read data valid
- mmio_addr_error  out  1  registered pulse: access to unmapped offset
- gpio_in  in  GPIO_W  asynchronous external inputs
- gpio_out  out  GPIO_W  GPIO output register
- timer_irq  out  1  level interrupt
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO not empty
- tx_ready  in  1  sink accepts head byte

## Operation
- Decode on offset bits [4:2]; bits [1:0] ignored; offset bits above [4] must be zero, else unmapped.
- Register map (offset, access, content):
  - 0x00 GPIO_OUT RW, [GPIO_W-1:0]
  - 0x04 GPIO_IN RO, 2-flop synchronized gpio_in
  - 0x08 TIMER_CNT RW, 32-bit
  - 0x0C TIMER_CMP RW, 32-bit
  - 0x10 TIMER_CTRL: bit0 enable RW, bit1 irq_en RW, bit2 pending (read; write 1 clears)
  - 0x14 TX_DATA WO: push wr_data[7:0]; reads return 0
  - 0x18 TX_STATUS: bit0 full, bit1 empty, bit2 overflow (sticky, write 1 clears), bits[8:4] count; other bits RO
- Unmapped offsets (0x1C, or upper bits nonzero): write ignored, read returns 0, mmio_addr_error pulses. Writes to RO fields are ignored, no error.
- Unused register bits read 0.
- Timer: when enable=1, CNT increments by 1 per cycle. When enable=1 and CNT==CMP: next CNT=0, pending set. CPU write to CNT overrides increment/wrap that cycle. Pending set and W1C in same cycle: set wins.
- timer_irq = pending & irq_en (combinational from flops).
- TX FIFO: push on write to 0x14. Pop when tx_valid & tx_ready. Push while full with no pop: dropped, overflow set. Push while full with simultaneous pop: accepted, count unchanged. Push on empty: tx_valid rises next cycle, never same cycle.
- Pointers wrap modulo TX_FIFO_DEPTH; count width clog2(DEPTH)+1.

## Timing
- Reset values: gpio_out 0, mmio_rd_data 0, mmio_rd_data_val 0, mmio_addr_error 0, timer_irq 0, tx_valid 0, tx_data 0. CNT, CMP, CTRL, GPIO sync flops, FIFO pointers, count and overflow are all 0.
- Read latency exactly 1 cycle: request at edge N, data and val registered at edge N+1. Back-to-back reads are supported every cycle.
- Read and write to the same register in the same cycle: read returns the pre-write value.
- Read of TX_STATUS reflects state before the same-cycle push/pop.
- Write effects are visible to reads issued the following cycle.
- GPIO_IN latency: 2 cycles synchronizer plus 1 cycle read.
- rst_n assertion mid-operation clears all state immediately, including FIFO contents and any in-flight read response.
- mmio_addr_error is asserted at edge N+1 for an unmapped access at N, whether read or write.

## Test plan
- Reset, then read every register (0x00..0x18) -> all return 0 except TX_STATUS = 0x2 (empty); rd_data_val is a 1-cycle pulse each time.
- Write CMP=5, CTRL=0x3, CNT=0 -> CNT counts 0..5, wraps to 0; pending and timer_irq rise the cycle after CNT==5. Write CTRL=0x7 -> irq clears. Test set and clear in the same cycle -> pending stays 1.
- Hold tx_ready=0 and push 0x41,0x42,0x43,0x44,0x45 -> status full=1, count=4, overflow=1. Raise tx_ready -> bytes 0x41..0x44 come out in order, then empty=1.
- With FIFO full, push 0x55 in the same cycle a pop occurs -> count stays 4, overflow stays 0, 0x55 is emitted last.
- Write GPIO_OUT=0xA5 and read it the same cycle -> read returns 0, gpio_out=0xA5; next read returns 0xA5. Drive gpio_in=0x3C -> GPIO_IN read 2 cycles later returns 0x3C.
- Write to 0x1C and read offset 0x20 -> both leave all state unchanged, read data is 0, and mmio_addr_error pulses once per access. Assert rst_n low while the FIFO is non-empty -> tx_valid drops to 0 immediately.
